// File: rtl/expr_string_check_if.sv
// Character-stream bus for expr_string_check: master drives characters and restart,
// slave returns the registered verdict (out/err) and the running operand count.
interface expr_string_check_if #(
  parameter int CNT_W = 8
);
  logic             restart;
  logic             in_valid;
  logic [7:0]       in;
  logic             out;
  logic             err;
  logic [CNT_W-1:0] op_cnt;

  modport master (
    output restart, in_valid, in,
    input  out, err, op_cnt
  );

  modport slave (
    input  restart, in_valid, in,
    output out, err, op_cnt
  );
endinterface

// File: rtl/expr_string_check.sv
// Infix-expression recogniser over an ASCII stream; parentheses enabled by EXPR_PAREN_EN.
// Latency: 1 cycle (all outputs registered).
// Backpressure: none, one character accepted per valid cycle.
module expr_string_check #(
  parameter int MAX_DIGITS = 4,
  parameter int MAX_DEPTH  = 3,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               clr_n,
  expr_string_check_if.slave bus
);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_NUM   = 2'd1,
`ifdef EXPR_PAREN_EN
    S_CLOSE = 2'd2,
`endif
    S_ERR   = 2'd3
  } state_t;

  localparam logic [3:0] DIG_MAX = 4'(MAX_DIGITS);

  state_t           state, state_nxt;
  logic [3:0]       dig_cnt, dig_nxt;
  logic [CNT_W-1:0] op_cnt, op_nxt;
  logic             out_q, out_nxt;
  logic             err_q, err_nxt;
  logic             is_dig, is_op;

  assign is_dig = (bus.in >= 8'h30) && (bus.in <= 8'h39);
  assign is_op  = (bus.in == 8'h2B) || (bus.in == 8'h2D) ||
                  (bus.in == 8'h2A) || (bus.in == 8'h2F);

`ifdef EXPR_PAREN_EN
  localparam logic [3:0] DEPTH_MAX = 4'(MAX_DEPTH);

  logic [3:0] depth, depth_nxt;
  logic       is_open, is_close;

  assign is_open  = (bus.in == 8'h28);
  assign is_close = (bus.in == 8'h29);
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= S_START;
      dig_cnt <= '0;
      op_cnt  <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef EXPR_PAREN_EN
      depth   <= '0;
`endif
    end else begin
      state   <= state_nxt;
      dig_cnt <= dig_nxt;
      op_cnt  <= op_nxt;
      out_q   <= out_nxt;
      err_q   <= err_nxt;
`ifdef EXPR_PAREN_EN
      depth   <= depth_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    dig_nxt   = dig_cnt;
    op_nxt    = op_cnt;
`ifdef EXPR_PAREN_EN
    depth_nxt = depth;
`endif
    if (bus.restart) begin
      state_nxt = S_START;
      dig_nxt   = '0;
      op_nxt    = '0;
`ifdef EXPR_PAREN_EN
      depth_nxt = '0;
`endif
    end else if (bus.in_valid) begin
      case (state)
        S_START: begin
          if (is_dig) begin
            state_nxt = S_NUM;
            dig_nxt   = 4'd1;
            if (op_cnt != '1) op_nxt = op_cnt + CNT_W'(1);
          end
`ifdef EXPR_PAREN_EN
          // An open at full depth falls through to the error branch.
          else if (is_open && depth != DEPTH_MAX) depth_nxt = depth + 4'd1;
`endif
          else state_nxt = S_ERR;
        end
        S_NUM: begin
          if (is_dig && dig_cnt != DIG_MAX) dig_nxt = dig_cnt + 4'd1;
          else if (is_op) state_nxt = S_START;
`ifdef EXPR_PAREN_EN
          else if (is_close && depth != 4'd0) begin
            state_nxt = S_CLOSE;
            depth_nxt = depth - 4'd1;
          end
`endif
          else state_nxt = S_ERR;
        end
`ifdef EXPR_PAREN_EN
        S_CLOSE: begin
          if (is_op) state_nxt = S_START;
          else if (is_close && depth != 4'd0) depth_nxt = depth - 4'd1;
          else state_nxt = S_ERR;
        end
`endif
        default: state_nxt = S_ERR;
      endcase
    end

`ifdef EXPR_PAREN_EN
    out_nxt = (state_nxt == S_NUM || state_nxt == S_CLOSE) && (depth_nxt == 4'd0);
`else
    out_nxt = (state_nxt == S_NUM);
`endif
    err_nxt = (state_nxt == S_ERR);
  end

  assign bus.out    = out_q;
  assign bus.err    = err_q;
  assign bus.op_cnt = op_cnt;

endmodule

// File: tb/tb_expr_string_check.sv
// Randomised and directed bench for expr_string_check; the reference model rescans the
// whole accepted string with adjacency rules and emits CHECKS/ERRORS at the end.
module tb_expr_string_check;

  localparam int MAX_DIGITS = 4;
  localparam int MAX_DEPTH  = 3;
  localparam int CNT_W      = 8;

  logic clk = 1'b0;
  logic clr_n;
  int   checks = 0;
  int   errors = 0;
  byte unsigned hist[$];

  always #5 clk = ~clk;

  expr_string_check_if #(.CNT_W(CNT_W)) bus ();

  expr_string_check #(
    .MAX_DIGITS(MAX_DIGITS),
    .MAX_DEPTH (MAX_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Classes: 1 digit, 2 op, 3 open, 4 close, 5 illegal.
  function automatic int cls_of(input byte unsigned c);
    if (c >= 8'h30 && c <= 8'h39) return 1;
    if (c == "+" || c == "-" || c == "*" || c == "/") return 2;
`ifdef EXPR_PAREN_EN
    if (c == "(") return 3;
    if (c == ")") return 4;
`endif
    return 5;
  endfunction

  // Judge the whole string since the last clear from what may follow what.
  function automatic void model(output logic m_out, output logic m_err, output int m_ops);
    int prev = 0, run = 0, dep = 0, ops = 0, c;
    bit bad = 0, ok;
    foreach (hist[i]) begin
      if (bad) break;
      c = cls_of(hist[i]);
      case (prev)
        0, 2, 3: ok = (c == 1 || c == 3);
        1:       ok = (c == 1 || c == 2 || c == 4);
        default: ok = (c == 2 || c == 4);
      endcase
      if (c == 1) begin
        run = (prev == 1) ? run + 1 : 1;
        if (run > MAX_DIGITS) ok = 0;
      end
      if (c == 3) begin
        dep++;
        if (dep > MAX_DEPTH) ok = 0;
      end
      if (c == 4) begin
        if (dep == 0) ok = 0;
        else dep--;
      end
      if (!ok) bad = 1;
      else begin
        if (c == 1 && prev != 1) ops++;
        prev = c;
      end
    end
    m_err = bad;
    m_out = !bad && (prev == 1 || prev == 4) && dep == 0;
    m_ops = (ops > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : ops;
  endfunction

  task automatic drive(input bit v, input byte unsigned ch, input bit rs);
    bus.in_valid = v;
    bus.in       = ch;
    bus.restart  = rs;
    @(posedge clk);
    #1;
    if (rs) hist.delete();
    else if (v) hist.push_back(ch);
    bus.in_valid = 1'b0;
    bus.restart  = 1'b0;
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) drive(1'b1, byte'(s[i]), 1'b0);
  endtask

  task automatic test_reset;
    clr_n = 1'b0;
    bus.restart = 1'b0; bus.in_valid = 1'b0; bus.in = 8'h00;
    #12;
    checks++;
    if (bus.out !== 1'b0 || bus.err !== 1'b0 || bus.op_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset: out=%b err=%b op_cnt=%0d, required 0 0 0", bus.out, bus.err, bus.op_cnt);
    end
    @(negedge clk) clr_n = 1'b1;
    drive(1'b0, 8'h31, 1'b0);
    checks++;
    if (bus.out !== 1'b0 || bus.err !== 1'b0 || bus.op_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_idle: out=%b err=%b op_cnt=%0d, required 0 0 0", bus.out, bus.err, bus.op_cnt);
    end
  endtask

  task automatic test_basic;
    string s = "1+2*3";
    logic [4:0] exp_out = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, byte'(s[i]), 1'b0);
      checks++;
      if (bus.out !== exp_out[4-i] || bus.err !== 1'b0) begin
        errors++;
        $display("FAIL basic_char%0d: out=%b err=%b, required out=%b err=0", i, bus.out, bus.err, exp_out[4-i]);
      end
    end
    checks++;
    if (bus.op_cnt !== 8'd3) begin
      errors++;
      $display("FAIL basic_opcnt: op_cnt=%0d, required 3", bus.op_cnt);
    end
  endtask

  task automatic test_multidigit;
    drive(1'b0, 8'h00, 1'b1);
    feed("1234+5");
    checks++;
    if (bus.out !== 1'b1 || bus.op_cnt !== 8'd2 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL multidigit_ok: out=%b err=%b op_cnt=%0d, required 1 0 2", bus.out, bus.err, bus.op_cnt);
    end
    drive(1'b0, 8'h00, 1'b1);
    feed("1234");
    checks++;
    if (bus.err !== 1'b0 || bus.out !== 1'b1) begin
      errors++;
      $display("FAIL multidigit_4: out=%b err=%b, required 1 0", bus.out, bus.err);
    end
    feed("5");
    checks++;
    if (bus.err !== 1'b1 || bus.out !== 1'b0 || bus.op_cnt !== 8'd1) begin
      errors++;
      $display("FAIL multidigit_5: out=%b err=%b op_cnt=%0d, required 0 1 1", bus.out, bus.err, bus.op_cnt);
    end
    feed("+1");
    checks++;
    if (bus.err !== 1'b1 || bus.out !== 1'b0 || bus.op_cnt !== 8'd1) begin
      errors++;
      $display("FAIL err_sticky: out=%b err=%b op_cnt=%0d, required 0 1 1", bus.out, bus.err, bus.op_cnt);
    end
  endtask

  task automatic test_restart_gaps;
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, "1", 1'b0);
    drive(1'b0, "5", 1'b0);
    drive(1'b0, "(", 1'b0);
    drive(1'b1, "+", 1'b0);
    drive(1'b0, "x", 1'b0);
    checks++;
    if (bus.out !== 1'b0 || bus.op_cnt !== 8'd1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL gap_hold: out=%b err=%b op_cnt=%0d, required 0 0 1", bus.out, bus.err, bus.op_cnt);
    end
    drive(1'b1, "9", 1'b1);
    checks++;
    if (bus.out !== 1'b0 || bus.op_cnt !== 8'd0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL restart_discard: out=%b err=%b op_cnt=%0d, required 0 0 0", bus.out, bus.err, bus.op_cnt);
    end
    drive(1'b1, "7", 1'b0);
    checks++;
    if (bus.out !== 1'b1 || bus.op_cnt !== 8'd1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL restart_then7: out=%b err=%b op_cnt=%0d, required 1 0 1", bus.out, bus.err, bus.op_cnt);
    end
  endtask

  task automatic test_async_reset;
    drive(1'b0, 8'h00, 1'b1);
    feed("12*");
    #3;
    clr_n = 1'b0;
    #1;
    hist.delete();
    checks++;
    if (bus.out !== 1'b0 || bus.err !== 1'b0 || bus.op_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_clear: out=%b err=%b op_cnt=%0d, required 0 0 0", bus.out, bus.err, bus.op_cnt);
    end
    @(negedge clk) clr_n = 1'b1;
    feed("4");
    checks++;
    if (bus.out !== 1'b1 || bus.op_cnt !== 8'd1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL async_then4: out=%b err=%b op_cnt=%0d, required 1 0 1", bus.out, bus.err, bus.op_cnt);
    end
  endtask

`ifdef EXPR_PAREN_EN
  task automatic test_paren;
    string s = "(1+(2))*3";
    logic [8:0] exp_out = 9'b000000101;
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, byte'(s[i]), 1'b0);
      checks++;
      if (bus.out !== exp_out[8-i] || bus.err !== 1'b0) begin
        errors++;
        $display("FAIL paren_char%0d: out=%b err=%b, required out=%b err=0", i, bus.out, bus.err, exp_out[8-i]);
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    feed("(((");
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL depth3: err=%b, required 0", bus.err);
    end
    feed("(");
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL depth4: err=%b, required 1", bus.err);
    end
    drive(1'b0, 8'h00, 1'b1);
    feed("1)");
    checks++;
    if (bus.err !== 1'b1 || bus.out !== 1'b0) begin
      errors++;
      $display("FAIL unmatched_close: out=%b err=%b, required 0 1", bus.out, bus.err);
    end
  endtask
`else
  task automatic test_noparen;
    drive(1'b0, 8'h00, 1'b1);
    feed("(");
    checks++;
    if (bus.err !== 1'b1 || bus.out !== 1'b0) begin
      errors++;
      $display("FAIL open_illegal: out=%b err=%b, required 0 1", bus.out, bus.err);
    end
  endtask
`endif

  task automatic test_saturation;
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 300; i++) feed("1+");
    feed("1");
    checks++;
    if (bus.op_cnt !== 8'd255 || bus.out !== 1'b1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL saturate: out=%b err=%b op_cnt=%0d, required 1 0 255", bus.out, bus.err, bus.op_cnt);
    end
  endtask

  task automatic test_random;
    string      ops = "+-*/";
    string      junk = "a =.";
    logic       m_out, m_err;
    int         m_ops, r, len;
    byte unsigned ch;
    for (int seq = 0; seq < 40; seq++) begin
      drive(1'b0, 8'h00, 1'b1);
      len = $urandom_range(1, 30);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 99);
        if (r < 50)      ch = 8'h30 + 8'($urandom_range(0, 9));
        else if (r < 75) ch = byte'(ops[$urandom_range(0, 3)]);
        else if (r < 84) ch = "(";
        else if (r < 93) ch = ")";
        else             ch = byte'(junk[$urandom_range(0, 3)]);
        r = $urandom_range(0, 99);
        if (r < 3)       drive(1'b1, ch, 1'b1);
        else if (r < 18) drive(1'b0, ch, 1'b0);
        else             drive(1'b1, ch, 1'b0);
        model(m_out, m_err, m_ops);
        checks++;
        if (bus.out !== m_out || bus.err !== m_err || bus.op_cnt !== CNT_W'(m_ops)) begin
          errors++;
          $display("FAIL random seq%0d step%0d: out=%b err=%b op_cnt=%0d, required %b %b %0d",
                   seq, k, bus.out, bus.err, bus.op_cnt, m_out, m_err, m_ops);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multidigit();
    test_restart_gaps();
    test_async_reset();
`ifdef EXPR_PAREN_EN
    test_paren();
`else
    test_noparen();
`endif
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/expr_string_check.md
# expr_string_check

Parametrised successor to the single-digit arithmetic-string recogniser in the P1 string-FSM family. It consumes one 8-bit ASCII character per accepted cycle and tracks whether the stream since the last clear forms a legal infix expression. Legal expressions use multi-digit operands, the operators `+ - * /` and, optionally, nested parentheses. It also reports a sticky error and a running operand count, and is the reference checker for the P1 expression benches.

## Interface
- `MAX_DIGITS`, 4: maximum consecutive digits in one operand; range 1–15.
- `MAX_DEPTH`, 3: maximum parenthesis nesting depth; range 1–15; used only with `EXPR_PAREN_EN`.
- `CNT_W`, 8: width of `op_cnt`.
- `clk`, input, 1: rising-edge clock.
- `clr_n`, input, 1: asynchronous active-low reset.
- `restart`, input, 1: synchronous clear of the recogniser; has priority over `in_valid`.
- `in_valid`, input, 1: `in` is sampled this cycle.
- `in`, input, 8: ASCII character.
- `out`, output, 1: the stream accepted so far is a complete legal expression.
- `err`, output, 1: sticky illegal-sequence flag.
- `op_cnt`, output, `CNT_W`: number of operands started since the last clear; saturating.

## Operation
- Character classes:
  - digit: 0x30–0x39
  - op: `+` 0x2B, `-` 0x2D, `*` 0x2A, `/` 0x2F
  - open: `(` 0x28
  - close: `)` 0x29
  - everything else is illegal.
- States:
  - START: expecting an operand; this is the reset state.
  - NUM: inside an operand.
  - CLOSE: just closed a parenthesis.
  - ERR: error, sticky.
- Internal registers:
  - `dig_cnt`: 4 bits.
  - `depth`: 4 bits, present only with `EXPR_PAREN_EN`.
- Transitions, taken only when `in_valid=1` and `restart=0`:
  - START
    - digit → NUM, `dig_cnt=1`, `op_cnt+1`.
    - open → START, `depth+1`; if `depth==MAX_DEPTH`, → ERR instead.
    - anything else → ERR.
  - NUM
    - digit → NUM, `dig_cnt+1`; if `dig_cnt==MAX_DIGITS`, → ERR instead.
    - op → START.
    - close with `depth>0` → CLOSE, `depth-1`.
    - anything else → ERR.
  - CLOSE
    - op → START.
    - close with `depth>0` → CLOSE, `depth-1`.
    - anything else → ERR.
  - ERR: stays in ERR on any character.
- `out = (state==NUM || state==CLOSE) && depth==0 && !err`.
- `err = (state==ERR)`.
- `op_cnt` saturates at 2^CNT_W−1 and does not change while in ERR.
- `restart=1` behaves like reset, but synchronously:
  - state → START; `dig_cnt`, `depth` and `op_cnt` → 0.
  - Any character presented in the same cycle is discarded.
- Leading zeros are legal: "007" is one operand of 3 digits.

## Timing
- Reset values: `out=0`, `err=0`, `op_cnt=0`, state START, `depth=0`, `dig_cnt=0`.
- `clr_n` low clears everything immediately, without waiting for a clock edge. It is deasserted synchronously by the system, and the first edge with `clr_n` high may accept a character.
- All outputs are registered. A character sampled at edge k is reflected in `out`, `err` and `op_cnt` after edge k.
- One character is accepted per cycle with no backpressure; latency is 1 cycle.
- `in_valid=0` holds all state; gaps between characters are allowed.
- `clr_n` asserted mid-expression discards the partial expression; there is no recovery.

## Configuration
- `EXPR_PAREN_EN` defined:
  - parenthesis handling as specified above;
  - `depth` register present;
  - CLOSE state reachable.
- `EXPR_PAREN_EN` undefined:
  - `(` and `)` are illegal characters and drive → ERR;
  - no `depth` register; treat `depth==0` as a constant;
  - CLOSE state removed;
  - `MAX_DEPTH` ignored.

## Test plan
- Basic expression, defaults: stream "1+2*3" one character per cycle.
  - `out` sequence 1,0,1,0,1.
  - `op_cnt` ends at 3; `err` stays 0.
- Multi-digit operands, `MAX_DIGITS=4`:
  - "1234+5" → `out=1`, `op_cnt=2`.
  - "12345" → `err=1` after the 5th character, `out=0`; `err` persists through a further "+1".
- Restart and gaps: "1+" with `in_valid` gaps, then `restart=1` with `in="9"` on the same cycle, then "7".
  - The 9 is ignored.
  - `out=1`, `op_cnt=1`.
- Asynchronous reset mid-stream: pull `clr_n` low between clock edges after "12*".
  - Outputs are 0 before the next edge.
  - "4" afterwards gives `out=1`, `op_cnt=1`.
- With `EXPR_PAREN_EN` and `MAX_DEPTH=3`:
  - "(1+(2))*3" → `out` is 0 until the final `)`, 1 at the final `)` and again after "3".
  - "((((1" → `err=1` on the 4th `(`.
  - "1)" → `err=1`.
- Without `EXPR_PAREN_EN`: "(1" → `err=1` on the first character.
